// File: rtl/calc_sequencer.sv
// Keyboard calculator sequencer: key events -> operand entry, ALU launch, result write.
// All outputs registered (strobes one cycle after the causing edge); no backpressure, keys outside entry states are dropped.
module calc_sequencer #(
  parameter int MAX_DIGITS = 9,
  parameter int ADDR_W     = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  output logic              opa_en,
  output logic              opb_en,
  output logic              opa_clr,
  output logic              opb_clr,
  output logic [3:0]        digit,
  output logic [3:0]        op_sel,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [31:0]       alu_result,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              result_valid,
  output logic              err,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0, ENTRY_B = 3'd1, START = 3'd2, WAIT = 3'd3, WRITE = 3'd4, SHOW = 3'd5
  } state_t;

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_DIGITS);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  state_t cur_state, nxt_state;
  logic [CW-1:0] cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
  logic [TW-1:0] wait_cnt, wait_cnt_nxt;
  logic opa_en_nxt, opb_en_nxt, opa_clr_nxt, opb_clr_nxt, alu_start_nxt, mem_wr_nxt;
  logic result_valid_nxt, err_nxt, clear, timeout;
  logic [3:0] digit_nxt, op_sel_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [31:0] mem_wdata_nxt;

  logic is_digit, is_op, is_unary, is_enter, is_esc;
  logic [3:0] dig_val, op_val;

  always_comb begin
    is_digit = 1'b1;
    dig_val  = 4'd0;
    case (key_code)
      8'h45: dig_val = 4'd0;
      8'h16: dig_val = 4'd1;
      8'h1E: dig_val = 4'd2;
      8'h26: dig_val = 4'd3;
      8'h25: dig_val = 4'd4;
      8'h2E: dig_val = 4'd5;
      8'h36: dig_val = 4'd6;
      8'h3D: dig_val = 4'd7;
      8'h3E: dig_val = 4'd8;
      8'h46: dig_val = 4'd9;
      default: is_digit = 1'b0;
    endcase
    is_op  = 1'b1;
    op_val = 4'd0;
    case (key_code)
      8'h15: op_val = 4'd0;
      8'h1D: op_val = 4'd1;
      8'h24: op_val = 4'd2;
      8'h2D: op_val = 4'd3;
      8'h2C: op_val = 4'd4;
      8'h35: op_val = 4'd5;
      8'h3C: op_val = 4'd6;
      8'h43: op_val = 4'd7;
      8'h44: op_val = 4'd8;
      8'h4D: op_val = 4'd9;
      8'h1C: op_val = 4'd10;
      8'h1B: op_val = 4'd11;
      8'h23: op_val = 4'd12;
      default: is_op = 1'b0;
    endcase
    // sen, cos and not take a single operand and skip B entry
    is_unary = is_op && (op_val == 4'd4 || op_val == 4'd5 || op_val == 4'd8);
    is_enter = (key_code == 8'h5A);
    is_esc   = (key_code == 8'h76);
  end

  always_comb begin
    nxt_state        = cur_state;
    opa_en_nxt       = 1'b0;
    opb_en_nxt       = 1'b0;
    opa_clr_nxt      = 1'b0;
    opb_clr_nxt      = 1'b0;
    alu_start_nxt    = 1'b0;
    mem_wr_nxt       = 1'b0;
    result_valid_nxt = 1'b0;
    digit_nxt        = digit;
    op_sel_nxt       = op_sel;
    mem_addr_nxt     = mem_addr;
    mem_wdata_nxt    = mem_wdata;
    err_nxt          = err;
    cnt_a_nxt        = cnt_a;
    cnt_b_nxt        = cnt_b;
    wait_cnt_nxt     = '0;
    clear            = 1'b0;
    timeout          = 1'b0;
    case (cur_state)
      ENTRY_A: if (key_valid) begin
        if (is_esc) clear = 1'b1;
        else if (is_digit) begin
          if (cnt_a < CNT_MAX) begin
            opa_en_nxt = 1'b1;
            digit_nxt  = dig_val;
            cnt_a_nxt  = cnt_a + 1'b1;
          end
        end else if (is_op && cnt_a != '0) begin
          op_sel_nxt = op_val;
          if (is_unary) begin
            nxt_state     = START;
            alu_start_nxt = 1'b1;
          end else nxt_state = ENTRY_B;
        end
      end
      ENTRY_B: if (key_valid) begin
        if (is_esc) clear = 1'b1;
        else if (is_digit) begin
          if (cnt_b < CNT_MAX) begin
            opb_en_nxt = 1'b1;
            digit_nxt  = dig_val;
            cnt_b_nxt  = cnt_b + 1'b1;
          end
        end else if (is_op && cnt_b == '0) begin
          op_sel_nxt = op_val;
          if (is_unary) begin
            nxt_state     = START;
            alu_start_nxt = 1'b1;
          end
        end else if (is_enter && cnt_b != '0) begin
          nxt_state     = START;
          alu_start_nxt = 1'b1;
        end
      end
      START: nxt_state = WAIT;
      WAIT: begin
        // escape beats a simultaneous alu_done so nothing is written
        if (key_valid && is_esc) clear = 1'b1;
        else if (alu_done) begin
          mem_wdata_nxt = alu_result;
          mem_wr_nxt    = 1'b1;
          nxt_state     = WRITE;
        end else if (wait_cnt == WAIT_LAST) begin
          clear   = 1'b1;
          timeout = 1'b1;
        end else wait_cnt_nxt = wait_cnt + 1'b1;
      end
      WRITE: begin
        nxt_state        = SHOW;
        result_valid_nxt = 1'b1;
        mem_addr_nxt     = mem_addr + 1'b1;
      end
      SHOW: begin
        if (key_valid && (is_enter || is_esc)) clear = 1'b1;
        else result_valid_nxt = 1'b1;
      end
      default: nxt_state = ENTRY_A;
    endcase
    if (clear) begin
      nxt_state   = ENTRY_A;
      opa_clr_nxt = 1'b1;
      opb_clr_nxt = 1'b1;
      cnt_a_nxt   = '0;
      cnt_b_nxt   = '0;
      err_nxt     = timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= ENTRY_A;
      opa_en       <= 1'b0;
      opb_en       <= 1'b0;
      opa_clr      <= 1'b0;
      opb_clr      <= 1'b0;
      alu_start    <= 1'b0;
      mem_wr       <= 1'b0;
      result_valid <= 1'b0;
      digit        <= 4'd0;
      op_sel       <= 4'd0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      err          <= 1'b0;
      cnt_a        <= '0;
      cnt_b        <= '0;
      wait_cnt     <= '0;
    end else begin
      cur_state    <= nxt_state;
      opa_en       <= opa_en_nxt;
      opb_en       <= opb_en_nxt;
      opa_clr      <= opa_clr_nxt;
      opb_clr      <= opb_clr_nxt;
      alu_start    <= alu_start_nxt;
      mem_wr       <= mem_wr_nxt;
      result_valid <= result_valid_nxt;
      digit        <= digit_nxt;
      op_sel       <= op_sel_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wdata    <= mem_wdata_nxt;
      err          <= err_nxt;
      cnt_a        <= cnt_a_nxt;
      cnt_b        <= cnt_b_nxt;
      wait_cnt     <= wait_cnt_nxt;
    end
  end

  assign state = cur_state;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Top-level sequencer for the keyboard calculator. Consumes decoded PS/2 key events (one-cycle strobes carrying the 8-bit make code) and steps through operand-A entry, operator selection, operand-B entry, ALU launch, result capture and result-memory write. Drives the enable/clear strobes of the two operand digit registers, the ALU operation select and start, and the result RAM write port. It is the only block that decides when an operand register accepts a digit or when memory is written.

## Interface
Parameters:
- MAX_DIGITS, 9: digits accepted per operand; further digits are ignored.
- ADDR_W, 4: result memory address width.
- TIMEOUT, 1024: cycles allowed in WAIT before error abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- key_valid  in  1  one-cycle strobe, new key event.
- key_code  in  8  make code, valid with key_valid (digits 0x45,16,1E,26,25,2E,36,3D,3E,46; + 15, - 1D, * 24, / 2D, sen 2C, cos 35, and 3C, or 43, not 44, nand 4D, nor 1C, xor 1B, xnor 23, enter 5A, escape 76).
- opa_en, opb_en  out  1  one-cycle: shift current digit into operand A/B.
- opa_clr, opb_clr  out  1  one-cycle: clear operand A/B.
- digit  out  4  binary digit value, valid with opa_en/opb_en.
- op_sel  out  4  latched operator: + 0, - 1, * 2, / 3, sen 4, cos 5, and 6, or 7, not 8, nand 9, nor 10, xor 11, xnor 12.
- alu_start  out  1  one-cycle ALU launch.
- alu_done  in  1  one-cycle, ALU result valid.
- alu_result  in  32  ALU result.
- mem_wr  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  captured result.
- result_valid  out  1  high in SHOW.
- err  out  1  sticky timeout flag, cleared by escape or reset.
- state  out  3  current state encoding, for display.

## Operation
- States (encoding): ENTRY_A 0, ENTRY_B 1, START 2, WAIT 3, WRITE 4, SHOW 5.
- Reset: state ENTRY_A; all strobes 0; op_sel 0; mem_addr 0; mem_wdata 0; digit 0; result_valid 0; err 0; digit counters 0.
- ENTRY_A: digit key with cnt_a < MAX_DIGITS → opa_en, cnt_a+1. Operator key with cnt_a ≥ 1 → latch op_sel; unary (sen, cos, not) → START, else → ENTRY_B. Operator with cnt_a = 0, or enter → ignored.
- ENTRY_B: digit key with cnt_b < MAX_DIGITS → opb_en, cnt_b+1. Operator key with cnt_b = 0 → replace op_sel (unary → START). Operator with cnt_b ≥ 1 → ignored. Enter with cnt_b ≥ 1 → START; with cnt_b = 0 → ignored.
- START: alu_start for one cycle → WAIT.
- WAIT: alu_done → capture alu_result into mem_wdata → WRITE. Escape → abort to ENTRY_A with no write. A TIMEOUT-cycle counter expiring → err = 1, abort to ENTRY_A.
- WRITE: mem_wr for one cycle at the current mem_addr. mem_addr increments on the following edge, wrapping 2^ADDR_W−1 → 0. Next state SHOW.
- SHOW: result_valid = 1. Enter or escape → ENTRY_A. Digits and operators are ignored.
- Escape in ENTRY_A, ENTRY_B, SHOW or WAIT → opa_clr and opb_clr pulse together, counters 0, err 0, next ENTRY_A. The same clear also happens on every entry to ENTRY_A from SHOW or a WAIT abort.
- Keys are ignored in START and WRITE, and in WAIT except escape.
- alu_done arriving in the same cycle as escape: escape wins and nothing is written. alu_done outside WAIT is ignored.

## Timing
- All outputs are registered. A strobe appears the cycle after the key_valid edge that caused it and lasts exactly one cycle.
- digit is valid in the same cycle as opa_en/opb_en.
- From enter in ENTRY_B: alu_start at +1. From alu_done: mem_wr at +1. result_valid rises at +2 after alu_done. mem_addr updates at +2.
- The WAIT counter starts at 0 on entry and errors when it reaches TIMEOUT−1 without alu_done.
- Reset asserted mid-operation, including during the WRITE cycle, suppresses any pending strobe on the next edge. No partial write is issued after reset.
- Back-to-back key_valid strobes on consecutive cycles are each processed.

## Test plan
- Keys 1E,26,15,2E,5A; ALU returns done with 0x23 after 5 cycles → opa_en digits 2,3; op_sel 0; opb_en digit 5; one alu_start; mem_wr with addr 0, data 0x23; result_valid high.
- Keys 16, 2C → op_sel 4, START entered directly with no opb_en; 5A before the operator is ignored.
- 10 digit keys for operand A with MAX_DIGITS 9 → exactly 9 opa_en pulses.
- ALU never completes → err = 1 after 1024 cycles, state 0, no mem_wr; escape clears err.
- 17 complete calculations with ADDR_W 4 → write addresses 0..15 then 0.
- Escape in the same cycle as alu_done → no mem_wr, opa_clr/opb_clr pulse; reset during WRITE → mem_wr low, mem_addr 0.
